// File: rtl/leaf_stream_fifo.sv
// rtl/leaf_stream_fifo.sv - valid/ready stream FIFO with occupancy; LEAF_FIFO_STATUS_EN adds sticky ovf/udf flags
module leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  level,
  input  logic              clr
`ifdef LEAF_FIFO_STATUS_EN
  ,
  output logic              ovf_sticky,
  output logic              udf_sticky
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push, pop;

  assign in_ready  = (level_q != CNT_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // clr wins over both handshakes; storage itself is left untouched
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

`ifdef LEAF_FIFO_STATUS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (in_valid & ~in_ready);
    udf_d = udf_q | (out_ready & ~out_valid);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_sticky = ovf_q;
  assign udf_sticky = udf_q;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// tb/tb_leaf_stream_fifo.sv - directed scoreboard bench for leaf_stream_fifo
module tb_leaf_stream_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       clr;
`ifdef LEAF_FIFO_STATUS_EN
  logic       ovf_sticky;
  logic       udf_sticky;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .clr       (clr)
`ifdef LEAF_FIFO_STATUS_EN
    ,
    .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then clock.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic c);
    int sz;
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
    sz = q.size();
    chk("level", 32'(level), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz != 4));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    if (sz != 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef LEAF_FIFO_STATUS_EN
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    chk("udf_sticky", 32'(udf_sticky), 32'(m_udf));
`endif
    do_push = iv && (sz < 4);
    do_pop  = ordy && (sz > 0);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (iv && sz == 4) m_ovf = 1'b1;
      if (ordy && sz == 0) m_udf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic pushes, no consumer
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_level3", 32'(level), 32'd3);
    chk("t1_head", 32'(out_data), 32'h11);

    // fill, reject a fifth word, drain
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // streaming at level 2 with simultaneous push/pop
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 2), 1'b1, 1'b0);
    chk("t3_level_hold", 32'(level), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // clr with a concurrent push
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset mid-stream
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_level", 32'(level), 32'd0);
    chk("t5_async_out_valid", 32'(out_valid), 32'd0);
    chk("t5_async_in_ready", 32'(in_ready), 32'd1);
    chk("t5_async_out_data", 32'(out_data), 32'd0);
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t5_latency_valid", 32'(out_valid), 32'd1);
    chk("t5_latency_data", 32'(out_data), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef LEAF_FIFO_STATUS_EN
    // sticky overflow / underflow flags
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_ovf_set", 32'(ovf_sticky), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_udf_set", 32'(udf_sticky), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_ovf_clr", 32'(ovf_sticky), 32'd0);
    chk("t6_udf_clr", 32'(udf_sticky), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
